// File: rtl/apb_pkg.sv
// Shared APB definitions: default widths, FSM state codes and the command record
// used by both the requester and its benches.
package apb_pkg;

   localparam int APB_ADDR_W  = 32;
   localparam int APB_DATA_W  = 32;
   localparam int APB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Plain constants mirror the enum so the FSM register stays a simple vector.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   typedef struct packed {
      logic                    write;
      logic [APB_ADDR_W-1:0]   addr;
      logic [APB_DATA_W-1:0]   wdata;
      logic [APB_DATA_W/8-1:0] strb;
   } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. o_expired flags the enabled cycle in which the
// count reaches TIMEOUT_CYCLES; it is tied low when TIMEOUT_CYCLES is 0.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int            CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The increment happening this cycle is the one that would reach the limit.
   assign o_expired = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB3/APB4 requester: a valid/ready command port in,
// one response pulse out per command, with an optional PREADY timeout.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_W,
   parameter int DATA_WIDTH     = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic                    PWRITE,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic                    PSEL,
   output logic                    PENABLE,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   output logic [1:0]              o_dbg_state
);

   // Command port handshake: a command transfers on a rising PCLK edge where
   // cmd_valid and cmd_ready are both high; cmd_ready is high only in IDLE.
   logic [1:0]              r_state;
   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_strb;
   logic                    r_rsp_valid;
   logic                    r_rsp_err;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    w_in_setup;
   logic                    w_wait_cycle;
   logic                    w_expired;

   assign w_in_setup   = (r_state == ST_SETUP);
   assign w_wait_cycle = (r_state == ST_ACCESS) && !PREADY;

   apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .i_clk     (PCLK),
      .i_rst     (PRESET),
      .i_clr     (w_in_setup),
      .i_en      (w_wait_cycle),
      .o_expired (w_expired)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_write <= cmd_write;
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_strb  <= cmd_strb;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: r_state <= ST_ACCESS;
            ST_ACCESS: begin
               // PREADY takes priority over a timeout landing in the same cycle.
               if (PREADY) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= PSLVERR;
                  r_rsp_rdata <= (!r_write && !PSLVERR) ? PRDATA : '0;
                  r_state     <= ST_IDLE;
               end else if (w_expired) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = (r_state == ST_IDLE);
   assign PSEL        = (r_state != ST_IDLE);
   assign PENABLE     = (r_state == ST_ACCESS);
   assign PADDR       = r_addr;
   assign PWRITE      = r_write;
   assign PWDATA      = r_wdata;
   assign PSTRB       = r_write ? r_strb : '0;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB memory completer, word-level reference
// memory with a response queue, directed cases followed by random commands.
module tb_apb_master;
   import apb_pkg::*;

   localparam int TMO   = 4;
   localparam int NEVER = 99;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic [3:0]  PSTRB;
   logic [1:0]  o_dbg_state;

   int          total = 0;
   int          bad = 0;
   logic [32:0] exp_q[$];
   logic [31:0] slv_mem[16];
   logic [31:0] model_mem[16];
   int          cur_wait = 0;
   bit          cur_err = 1'b0;
   bit          cur_force = 1'b0;
   int          acc_cnt = 0;

   always #5 PCLK = ~PCLK;

   apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .o_dbg_state(o_dbg_state)
   );

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Memory completer: PREADY after cur_wait low ACCESS cycles, garbage outside ACCESS.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         PREADY  = (acc_cnt >= cur_wait);
         PSLVERR = cur_err;
         PRDATA  = cur_force ? 32'hDEAD_BEEF : slv_mem[PADDR[5:2]];
         if (PREADY && PWRITE && !cur_err)
            slv_mem[PADDR[5:2]] = merge(slv_mem[PADDR[5:2]], PWDATA, PSTRB);
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         PREADY  = 1'b0;
         PSLVERR = 1'($urandom);
         PRDATA  = $urandom;
      end
   end

   // Protocol monitor and response scoreboard.
   always @(negedge PCLK) begin
      logic [32:0] e;
      if (!PRESET) begin
         check("penable_without_psel", {79'd0, PENABLE & ~PSEL}, 80'd0);
         check("pstrb_on_read", (PSEL && !PWRITE) ? PSTRB : 4'h0, 80'd0);
         if (rsp_valid) begin
            check("rsp_expected", exp_q.size() != 0, 80'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rsp_err_rdata", {rsp_err, rsp_rdata}, e);
            end
         end
      end
   end

   task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input int wt, input bit er, input bit frc);
      int k, n;
      logic [32:0] e;
      if (wt >= TMO) begin
         k = 2 + TMO;
         e = {1'b1, 32'h0};
      end else begin
         k = 3 + wt;
         e = {er, (!wr && !er) ? model_mem[addr[5:2]] : 32'h0};
         if (wr && !er) model_mem[addr[5:2]] = merge(model_mem[addr[5:2]], wd, strb);
      end
      exp_q.push_back(e);
      @(negedge PCLK);
      cur_wait = wt; cur_err = er; cur_force = frc;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = strb;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      check("cmd_accepted", n < 20, 80'd1);
      @(negedge PCLK);
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_strb = 4'($urandom);
      n = 1;
      while (!rsp_valid && n < 40) begin
         check("bus_during_transfer", {PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA},
               {1'b1, (n >= 2), wr, wr ? strb : 4'h0, addr, wd});
         @(negedge PCLK);
         n++;
      end
      check("rsp_cycle", n, k);
      check("idle_at_rsp", {cmd_ready, PSEL}, 80'b10);
   endtask

   task automatic back_to_back();
      bit          wr[3];
      logic [31:0] ad[3], wd[3];
      int          acc[3];
      int          idx;
      wr = '{1'b1, 1'b1, 1'b0};
      ad = '{32'h10, 32'h14, 32'h10};
      wd = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h0};
      acc = '{-1, -1, -1};
      for (int i = 0; i < 3; i++) begin
         if (wr[i]) begin
            exp_q.push_back({1'b0, 32'h0});
            model_mem[ad[i][5:2]] = wd[i];
         end else begin
            exp_q.push_back({1'b0, model_mem[ad[i][5:2]]});
         end
      end
      @(negedge PCLK);
      cur_wait = 0; cur_err = 1'b0; cur_force = 1'b0;
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         if (idx < 3) begin
            cmd_valid = 1'b1; cmd_write = wr[idx]; cmd_addr = ad[idx];
            cmd_wdata = wd[idx]; cmd_strb = 4'hF;
         end else begin
            cmd_valid = 1'b0;
         end
         if (cmd_valid && cmd_ready) begin
            acc[idx] = c;
            idx++;
         end
         @(negedge PCLK);
      end
      check("b2b_accept0", acc[0], 80'd0);
      check("b2b_accept1", acc[1], 80'd3);
      check("b2b_accept2", acc[2], 80'd6);
   endtask

   task automatic reset_abort();
      @(negedge PCLK);
      cur_wait = NEVER; cur_err = 1'b0; cur_force = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFE_F00D;
      cmd_strb = 4'hF;
      check("abort_ready", cmd_ready, 80'd1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      check("abort_in_access", {PSEL, PENABLE}, 80'b11);
      @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      check("abort_bus_dropped", {PSEL, PENABLE, rsp_valid, o_dbg_state}, {3'b000, ST_IDLE});
      PRESET = 1'b0;
      cur_wait = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         check("abort_no_rsp", {rsp_valid, cmd_ready}, 80'b01);
      end
   endtask

   initial begin
      bit          wr, er, frc;
      int          wt;
      logic [31:0] ad, wd;
      logic [3:0]  st;
      PRESET = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h1234;
      cmd_strb = 4'hF;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      for (int i = 0; i < 16; i++) begin
         slv_mem[i] = '0;
         model_mem[i] = '0;
      end
      repeat (2) @(negedge PCLK);
      check("rst_ctrl", {PSEL, PENABLE, PWRITE, PSTRB, rsp_valid, rsp_err, o_dbg_state}, 80'd0);
      check("rst_paddr", PADDR, 80'd0);
      check("rst_pwdata", PWDATA, 80'd0);
      check("rst_rsp_rdata", rsp_rdata, 80'd0);
      check("rst_cmd_ready", cmd_ready, 80'd1);
      PRESET = 1'b0;
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         check("idle_psel_low", PSEL, 80'd0);
      end

      do_cmd(1'b1, 32'h04, 32'hA5A5_0001, 4'hF, 0, 1'b0, 1'b0);
      do_cmd(1'b0, 32'h04, 32'h0, 4'hF, 0, 1'b0, 1'b0);
      do_cmd(1'b1, 32'h08, 32'h1122_3344, 4'h5, 3, 1'b0, 1'b0);
      do_cmd(1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0, 1'b0);
      do_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 1, 1'b1, 1'b1);
      do_cmd(1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, NEVER, 1'b0, 1'b0);
      do_cmd(1'b0, 32'h0C, 32'h0, 4'h0, NEVER, 1'b0, 1'b0);
      do_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 3, 1'b0, 1'b0);
      back_to_back();
      reset_abort();
      do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         wr  = 1'($urandom_range(0, 1));
         ad  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         wd  = $urandom;
         st  = 4'($urandom_range(0, 15));
         wt  = $urandom_range(0, 5);
         if (wt == 5) wt = NEVER;
         er  = ($urandom_range(0, 7) == 0);
         frc = er ? 1'($urandom_range(0, 1)) : 1'b0;
         do_cmd(wr, ad, wd, st, wt, er, frc);
      end

      repeat (3) @(negedge PCLK);
      check("scoreboard_drained", exp_q.size(), 80'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
